// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply sequencer driving mon_prod: walks the exponent MSB-first, one product per step.
// Optional feature: define MOD_EXP_CTRL_PERF_EN to add the perf_issued start counter output.
module mod_exp_ctrl #(
    parameter int EBITS   = 1024,
    parameter int LBITS   = 11,
    parameter int CNTBITS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [EBITS-1:0]   exponent,
    input  logic [LBITS-1:0]   exp_len,
    input  logic [CNTBITS-1:0] cfg_count,
    output logic               mp_start,
    output logic [1:0]         mp_op_code,
    output logic [CNTBITS-1:0] mp_count,
    input  logic               mp_stop,
    output logic               busy,
`ifdef MOD_EXP_CTRL_PERF_EN
    output logic [15:0]        perf_issued,
`endif
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_XX = 2'd0;
    localparam logic [1:0] OP_XM = 2'd1;
    localparam logic [1:0] OP_X1 = 2'd2;

    state_t             state_q, state_d;
    logic [EBITS-1:0]   exp_q, exp_d;
    logic [LBITS-1:0]   ptr_q, ptr_d;
    logic [1:0]         op_q, op_d;
    logic [CNTBITS-1:0] count_q, count_d;
    logic               busy_q, busy_d;
    logic [LBITS-1:0]   len_c;
    logic               exp_bit;
    logic               go_accept;

    assign len_c     = (exp_len > LBITS'(EBITS)) ? LBITS'(EBITS) : exp_len;
    assign exp_bit   = |(exp_q & (EBITS'(1) << ptr_q));
    assign go_accept = (state_q == S_IDLE) && go;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        count_d = count_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    exp_d   = exponent;
                    count_d = cfg_count;
                    ptr_d   = len_c - LBITS'(1);
                    busy_d  = 1'b1;
                    op_d    = (len_c == '0) ? OP_X1 : OP_XX;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_GUARD;
            // A stop still high from the previous product is not looked at here.
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (mp_stop) begin
                    state_d = S_ISSUE;
                    if (op_q == OP_XX && exp_bit) begin
                        op_d = OP_XM;
                    end else if (op_q == OP_X1) begin
                        state_d = S_DONE;
                    end else if (ptr_q == '0) begin
                        op_d = OP_X1;
                    end else begin
                        ptr_d = ptr_q - LBITS'(1);
                        op_d  = OP_XX;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            exp_q   <= '0;
            ptr_q   <= '0;
            op_q    <= OP_XX;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign mp_start   = (state_q == S_ISSUE);
    assign done       = (state_q == S_DONE);
    assign busy       = busy_q;
    assign mp_op_code = op_q;
    assign mp_count   = count_q;

`ifdef MOD_EXP_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (go_accept) begin
            perf_d = '0;
        end else if (mp_start && perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_issued = perf_q;
`else
    logic unused_go_accept;
    assign unused_go_accept = go_accept;
`endif

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a mon_prod stub whose stop drops on start and rises after a fixed delay.
module tb_mod_exp_ctrl;
    localparam int EBITS   = 16;
    localparam int LBITS   = 5;
    localparam int CNTBITS = 11;
    localparam int N       = 5;
    localparam logic [1:0] XX = 2'd0;
    localparam logic [1:0] XM = 2'd1;
    localparam logic [1:0] X1 = 2'd2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               go = 1'b0;
    logic [EBITS-1:0]   exponent = '0;
    logic [LBITS-1:0]   exp_len = '0;
    logic [CNTBITS-1:0] cfg_count = '0;
    logic               mp_start;
    logic [1:0]         mp_op_code;
    logic [CNTBITS-1:0] mp_count;
    logic               mp_stop = 1'b1;
    logic               busy;
    logic               done;
`ifdef MOD_EXP_CTRL_PERF_EN
    logic [15:0]        perf_issued;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stub_cnt = 0;
    logic [1:0] sb[$];
    int cnt_exp = 0;
    int n_starts = 0;
    int done_cnt = 0;
    int busy_cycles = 0;
    int last_start = -1;
    int first_start = -1;
    int done_cyc = -1;

    mod_exp_ctrl #(
        .EBITS(EBITS), .LBITS(LBITS), .CNTBITS(CNTBITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .exponent(exponent), .exp_len(exp_len),
        .cfg_count(cfg_count), .mp_start(mp_start), .mp_op_code(mp_op_code),
        .mp_count(mp_count), .mp_stop(mp_stop), .busy(busy),
`ifdef MOD_EXP_CTRL_PERF_EN
        .perf_issued(perf_issued),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // mon_prod stub: not reset, so a product in flight keeps running across a controller reset.
    always @(posedge clk) begin
        if (mp_start) begin
            mp_stop  <= 1'b0;
            stub_cnt <= N;
        end else if (!mp_stop) begin
            if (stub_cnt == 0) mp_stop <= 1'b1;
            else stub_cnt <= stub_cnt - 1;
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mp_start) begin
            if (sb.size() == 0) check_val("unexpected_start", 1, 0);
            else check_val("op_code", int'(mp_op_code), int'(sb.pop_front()));
            check_val("mp_count", int'(mp_count), cnt_exp);
            if (last_start >= 0) check_val("start_gap", cyc - last_start, N + 3);
            else first_start = cyc;
            last_start = cyc;
            n_starts++;
            $display("start cycle=%0d op=%0d count=%0d", cyc, mp_op_code, mp_count);
        end
        if (busy) busy_cycles++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic prep(input logic [EBITS-1:0] e, input int len, input int cnt, output int n_exp);
        int lc;
        lc = (len > EBITS) ? EBITS : len;
        sb.delete();
        for (int i = lc - 1; i >= 0; i--) begin
            sb.push_back(XX);
            if (e[i]) sb.push_back(XM);
        end
        sb.push_back(X1);
        n_exp       = sb.size();
        cnt_exp     = cnt;
        n_starts    = 0;
        done_cnt    = 0;
        busy_cycles = 0;
        last_start  = -1;
        first_start = -1;
        done_cyc    = -1;
    endtask

    task automatic run_exp(input logic [EBITS-1:0] e, input int len, input int cnt, input bit mid_go);
        int n_exp;
        int t;
        int go_cyc;
        prep(e, len, cnt, n_exp);
        go = 1'b1; exponent = e; exp_len = LBITS'(len); cfg_count = CNTBITS'(cnt);
        go_cyc = cyc;
        @(posedge clk); #1;
        go = 1'b0; exponent = ~e; cfg_count = ~CNTBITS'(cnt);
`ifdef MOD_EXP_CTRL_PERF_EN
        check_val("perf_clear", int'(perf_issued), 0);
`endif
        t = 0;
        while (done_cnt == 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
            go = (mid_go && t == 12);
        end
        go = 1'b0;
        if (done_cnt == 0) check_val("done_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
        check_val("done_pulses", done_cnt, 1);
        check_val("num_starts", n_starts, n_exp);
        check_val("sb_left", sb.size(), 0);
        check_val("go_latency", first_start - go_cyc, 1);
        check_val("done_latency", done_cyc - last_start, N + 3);
        check_val("busy_cycles", busy_cycles, n_exp * (N + 3) + 1);
        check_val("busy_after", int'(busy), 0);
`ifdef MOD_EXP_CTRL_PERF_EN
        check_val("perf_final", int'(perf_issued), n_exp);
`endif
        $display("run e=%h len=%0d starts=%0d busy=%0d", e, len, n_starts, busy_cycles);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_start"}, int'(mp_start), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_op"}, int'(mp_op_code), 0);
        check_val({tag, "_count"}, int'(mp_count), 0);
`ifdef MOD_EXP_CTRL_PERF_EN
        check_val({tag, "_perf"}, int'(perf_issued), 0);
`endif
    endtask

    initial begin
        int n_exp;
        int t;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_exp(16'b1011, 4, 1024, 1'b0);
        run_exp(16'hFFFF, 0, 7, 1'b0);
        run_exp(16'h0000, 1, 1024, 1'b0);
        run_exp(16'h00A5, 8, 300, 1'b0);
        run_exp(16'b1011, 4, 55, 1'b1);
        run_exp(16'h8001, 20, 12, 1'b0);

        // Reset during WAIT of the XM product, with go asserted in the same cycle.
        prep(16'b1011, 4, 99, n_exp);
        go = 1'b1; exponent = 16'b1011; exp_len = 4; cfg_count = 99;
        @(posedge clk); #1;
        go = 1'b0;
        t = 0;
        while (n_starts < 2 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (n_starts < 2) check_val("xm_timeout", n_starts, 2);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0; go = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; go = 1'b0;
        check_idle_outputs("midreset");
        repeat (10) @(posedge clk);
        #1;
        check_val("idle_hold", n_starts, 2);
        check_val("idle_busy", int'(busy), 0);
        t = 0;
        while (!mp_stop && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_val("stub_stop", int'(mp_stop), 1);
        sb.delete();
        $display("reset mid-run handled at cycle=%0d", cyc);

        run_exp(16'b1011, 4, 1024, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
